// File: rtl/haze_fixed_pkg.sv
// Fixed-point formats and helpers shared across the haze-removal recovery datapath.
package haze_fixed_pkg;

  localparam int unsigned TRANS_IN_W     = 8;    // dark-channel estimate, Q0.8
  localparam int unsigned RECIP_OUT_W    = 8;    // 1/t result width
  localparam int unsigned RECIP_OUT_FRAC = 6;    // 1/t result is Q2.6
  localparam int unsigned RECIP_SEG_BITS = 4;    // 16 interpolation segments
  localparam int unsigned T_FLOOR_CLAMP  = 167;  // x ceiling, keeps t above ~0.35

  // Integer encoding of 1.0 in a format with frac_bits fractional bits.
  function automatic int unsigned one_q(input int unsigned frac_bits);
    return 32'd1 << frac_bits;
  endfunction

  // Half-LSB bias added before dropping 'shift' bits (round half up).
  function automatic int unsigned round_bias(input int unsigned shift);
    return (shift == 0) ? 32'd0 : (32'd1 << (shift - 1));
  endfunction

  // Table entry k: round(1.0 / (1 - k/2**seg_bits)) in the output format, clipped to full scale.
  function automatic int unsigned recip_entry(input int unsigned k,
                                              input int unsigned seg_bits,
                                              input int unsigned out_frac,
                                              input int unsigned out_w);
    int unsigned max_v;
    int unsigned den;
    int unsigned num;
    int unsigned q;
    max_v = (32'd1 << out_w) - 32'd1;
    den   = (32'd1 << seg_bits) - k;
    num   = one_q(out_frac) << seg_bits;
    if (den == 32'd0) q = max_v;
    else              q = (32'd2 * num + den) / (32'd2 * den);
    return (q > max_v) ? max_v : q;
  endfunction

endpackage

// File: rtl/reciprocal_table_ram.sv
// Coarse 1/(1-x) breakpoint table: one write port, two registered read-first read ports.
module reciprocal_table_ram
  import haze_fixed_pkg::*;
#(
  parameter int unsigned SEG_BITS = RECIP_SEG_BITS,
  parameter int unsigned OUT_W    = RECIP_OUT_W,
  parameter int unsigned OUT_FRAC = RECIP_OUT_FRAC
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SEG_BITS:0] waddr,
  input  logic [OUT_W-1:0]  wdata,
  input  logic              re,
  input  logic [SEG_BITS:0] raddr_a,
  input  logic [SEG_BITS:0] raddr_b,
  output logic [OUT_W-1:0]  rdata_a,
  output logic [OUT_W-1:0]  rdata_b
);

  localparam int unsigned AW    = SEG_BITS + 1;
  localparam int unsigned DEPTH = (1 << SEG_BITS) + 1;

  typedef logic [DEPTH-1:0][OUT_W-1:0] table_t;

  function automatic table_t init_table();
    table_t t;
    t = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      t[AW'(k)] = OUT_W'(recip_entry(k, SEG_BITS, OUT_FRAC, OUT_W));
    end
    return t;
  endfunction

  // Contents survive reset; only the elaboration-time image seeds them.
  table_t mem = init_table();

  logic waddr_ok;
  assign waddr_ok = (waddr <= AW'(DEPTH - 1));

  // Non-blocking write and read in one block gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we && waddr_ok) mem[waddr] <= wdata;
    if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/transmission_reciprocal_unit.sv
// Streaming 1/(1-x) unit: clamp and split x, read two breakpoints, interpolate with rounding and saturation.
module transmission_reciprocal_unit
  import haze_fixed_pkg::*;
#(
  parameter int unsigned IN_W          = TRANS_IN_W,
  parameter int unsigned OUT_W         = RECIP_OUT_W,
  parameter int unsigned OUT_FRAC      = RECIP_OUT_FRAC,
  parameter int unsigned SEG_BITS      = RECIP_SEG_BITS,
  parameter int unsigned CLAMP_DEFAULT = T_FLOOR_CLAMP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_BITS:0] cfg_addr,
  input  logic [OUT_W-1:0]  cfg_wdata,
  input  logic              cfg_clamp_we,
  input  logic [IN_W-1:0]   cfg_clamp,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned F     = IN_W - SEG_BITS;
  localparam int unsigned FW    = (F > 0) ? F : 1;
  localparam int unsigned AW    = SEG_BITS + 1;
  localparam int unsigned PW    = OUT_W + FW + 3;
  localparam int unsigned MAX_V = (1 << OUT_W) - 1;
  localparam int unsigned BIAS  = round_bias(F);

  logic                en;
  logic [IN_W-1:0]     clamp;
  logic [IN_W-1:0]     x_c;
  logic [SEG_BITS-1:0] idx_c;
  logic [FW-1:0]       frac_c;
  logic                v1;
  logic                v2;
  logic                sat1;
  logic                sat2;
  logic [SEG_BITS-1:0] idx1;
  logic [FW-1:0]       frac1;
  logic [FW-1:0]       frac2;
  logic [OUT_W-1:0]    t_lo;
  logic [OUT_W-1:0]    t_hi;
  logic [AW-1:0]       raddr_lo;
  logic [AW-1:0]       raddr_hi;
  logic signed [PW-1:0] t_lo_s;
  logic signed [PW-1:0] t_hi_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] y_s;
  logic [OUT_W-1:0]    y_c;
  logic                sat_c;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // S1 combinational: apply the t floor, split into segment index and fraction.
  always_comb begin
    x_c    = (in_data > clamp) ? clamp : in_data;
    idx_c  = x_c[IN_W-1 -: SEG_BITS];
    frac_c = '0;
    if (F > 0) frac_c = x_c[FW-1:0];
  end

  assign raddr_lo = {1'b0, idx1};
  assign raddr_hi = {1'b0, idx1} + AW'(1);

  reciprocal_table_ram #(
    .SEG_BITS (SEG_BITS),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC)
  ) u_table (
    .clk     (clk),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wdata   (cfg_wdata),
    .re      (en),
    .raddr_a (raddr_lo),
    .raddr_b (raddr_hi),
    .rdata_a (t_lo),
    .rdata_b (t_hi)
  );

  // S3 combinational: y = T[i] + round((T[i+1]-T[i]) * frac / 2**F), then clip to the output range.
  // Reaching full scale is flagged: the top breakpoints are themselves clipped values of 1/t.
  always_comb begin
    y_c    = '0;
    sat_c  = sat2;
    t_lo_s = $signed(PW'(t_lo));
    t_hi_s = $signed(PW'(t_hi));
    prod_s = (t_hi_s - t_lo_s) * $signed(PW'(frac2));
    y_s    = t_lo_s + ((prod_s + $signed(PW'(BIAS))) >>> F);
    if (y_s[PW-1]) begin
      y_c = '0;
    end else if (y_s >= $signed(PW'(MAX_V))) begin
      y_c   = OUT_W'(MAX_V);
      sat_c = 1'b1;
    end else begin
      y_c = OUT_W'(y_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      clamp     <= IN_W'(CLAMP_DEFAULT);
    end else begin
      if (cfg_clamp_we) clamp <= cfg_clamp;
      if (en) begin
        v1        <= in_valid;
        idx1      <= idx_c;
        frac1     <= frac_c;
        sat1      <= (in_data > clamp);
        v2        <= v1;
        frac2     <= frac1;
        sat2      <= sat1;
        out_valid <= v2;
        if (v2) begin
          out_data <= y_c;
          out_sat  <= sat_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_transmission_reciprocal_unit.sv
// Directed and randomized checks of the 1/(1-x) unit against a real-arithmetic reference.
module tb_transmission_reciprocal_unit;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_clamp_we;
  logic [7:0] cfg_clamp;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int  tests;
  int  fails;
  int  tbl [17];
  int  clamp_m;
  real r;
  int  ry;
  int  rs;
  int  rd;

  transmission_reciprocal_unit dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_clamp_we (cfg_clamp_we),
    .cfg_clamp    (cfg_clamp),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sat      (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 1/t = 64 / (1 - x_clamped/256) approximated by linear interpolation of the table.
  function automatic void model(input int din, input int clampv, output int y, output int sat);
    int x;
    int idx;
    int frac;
    int d;
    x    = (din > clampv) ? clampv : din;
    idx  = x / 16;
    frac = x % 16;
    d    = tbl[idx + 1] - tbl[idx];
    y    = tbl[idx] + int'($floor(real'(d * frac + 8) / 16.0));
    sat  = (din > clampv) ? 1 : 0;
    if (y < 0) y = 0;
    if (y >= 255) begin
      y   = 255;
      sat = 1;
    end
  endfunction

  task automatic write_clamp(input int v);
    cfg_clamp_we = 1'b1;
    cfg_clamp    = 8'(v);
    @(posedge clk); #1;
    cfg_clamp_we = 1'b0;
    clamp_m      = v;
  endtask

  task automatic write_tbl(input int a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = 5'(a);
    cfg_wdata = 8'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a <= 16) tbl[a] = d;
  endtask

  // One isolated sample on an idle pipeline; result must appear exactly three cycles after presentation.
  task automatic send_check(input string tag, input int din, input int exp_y, input int exp_s);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = 8'(din);
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_y));
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    @(posedge clk); #1;
  endtask

  // Streams n random samples; forced_stall holds out_ready low for the first 8 cycles, else random backpressure.
  task automatic stream(input int n, input bit forced_stall);
    int vals[$];
    int exp_y[$];
    int exp_s[$];
    int sent;
    int got;
    int y;
    int s;
    bit holding;
    bit acc_in;
    bit acc_out;
    logic [7:0] held_d;
    logic held_s;
    for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(0, 255)));
    sent    = 0;
    got     = 0;
    holding = 1'b0;
    held_d  = '0;
    held_s  = 1'b0;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      out_ready = forced_stall ? (cyc >= 8) : ($urandom_range(0, 2) != 0);
      in_valid  = (sent < n) && (forced_stall || $urandom_range(0, 3) != 0);
      in_data   = (sent < n) ? 8'(vals[sent]) : 8'h00;
      @(negedge clk);
      if (holding) begin
        check("stall_data", 32'(out_data), 32'(held_d));
        check("stall_sat", 32'(out_sat), 32'(held_s));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        holding = 1'b1;
        held_d  = out_data;
        held_s  = out_sat;
      end else begin
        holding = 1'b0;
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_in) begin
        model(vals[sent], clamp_m, y, s);
        exp_y.push_back(y);
        exp_s.push_back(s);
        sent++;
      end
      if (acc_out) begin
        check("stream_expected_out", 32'(exp_y.size() != 0), 32'd1);
        if (exp_y.size() != 0) begin
          y = exp_y.pop_front();
          s = exp_s.pop_front();
          check("stream_data", 32'(out_data), 32'(y));
          check("stream_sat", 32'(out_sat), 32'(s));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    check("stream_complete", 32'(got), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin
        tbl[k] = 255;
      end else begin
        r      = 64.0 / (1.0 - real'(k) / 16.0);
        tbl[k] = int'($floor(r + 0.5));
        if (tbl[k] > 255) tbl[k] = 255;
      end
    end
    clamp_m      = 167;
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    cfg_clamp_we = 1'b0;
    cfg_clamp    = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Default table and clamp.
    send_check("in0", 0, 'h40, 0);
    send_check("in128", 128, 'h80, 0);
    send_check("in200_clamped", 200, 'hBA, 1);

    // Clamp opened fully: top segment reaches full scale.
    write_clamp(255);
    send_check("in250_fullscale", 250, 'hFF, 1);

    // Table rewrite of entry 0.
    write_tbl(0, 'h50);
    send_check("wr0", 0, 'h50, 0);

    // Write to entry 0 on the same edge that reads it: old value is returned.
    in_valid = 1'b1;
    in_data  = 8'd0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cfg_we    = 1'b1;
    cfg_addr  = 5'd0;
    cfg_wdata = 8'h60;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tbl[0] = 'h60;
    @(posedge clk); #1;
    check("same_cycle_valid", 32'(out_valid), 32'd1);
    check("same_cycle_old", 32'(out_data), 32'h50);
    @(posedge clk); #1;
    send_check("wr0_new", 0, 'h60, 0);

    // Out-of-range address must not disturb the table.
    write_tbl(20, 'h00);
    send_check("bad_addr_lo", 0, 'h60, 0);
    send_check("bad_addr_hi", 255, 'hFF, 1);

    for (int i = 0; i < 6; i++) begin
      rd = int'($urandom_range(0, 255));
      model(rd, clamp_m, ry, rs);
      send_check("rand_single", rd, ry, rs);
    end

    // Reset with two samples in flight.
    in_valid = 1'b1;
    in_data  = 8'd100;
    @(posedge clk); #1;
    in_data = 8'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst     = 1'b0;
    clamp_m = 167;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send_check("post_rst_clamp", 200, 'hBA, 1);
    send_check("post_rst_table", 0, 'h60, 0);

    // Four back-to-back samples against a five-cycle output stall.
    stream(4, 1'b1);

    for (int rnd = 0; rnd < 4; rnd++) begin
      write_clamp(int'($urandom_range(0, 255)));
      write_tbl(int'($urandom_range(0, 16)), int'($urandom_range(0, 255)));
      stream(16, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
